// File: rtl/col_ext_pkg.sv
// col_ext_pkg: shared widths, FSM states and lane intersection helper for col_extract_mc
package col_ext_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, OUT} state_t;
    function automatic int off_w(input int row_bytes_max);
        return $clog2(row_bytes_max);
    endfunction
    function automatic int len_w(input int max_col_bytes);
        return $clog2(max_col_bytes) + 1;
    endfunction
    function automatic logic lane_hit(input int unsigned base, input int unsigned off,
                                      input int unsigned len, input int unsigned lane);
        return (base + lane >= off) && (base + lane < off + len);
    endfunction
endpackage

// File: rtl/col_extract_mc_if.sv
// col_extract_mc_if: beat stream, column config and packed-row result bundle
interface col_extract_mc_if import col_ext_pkg::*; #(
    parameter int BUS_BYTES     = 16,
    parameter int MAX_COL_BYTES = 64,
    parameter int NUM_COLS      = 4,
    parameter int ROW_BYTES_MAX = 256
);
    localparam int OFF_W = off_w(ROW_BYTES_MAX);
    localparam int LEN_W = len_w(MAX_COL_BYTES);
    logic                            i_start;
    logic [NUM_COLS*OFF_W-1:0]       i_col_off;
    logic [NUM_COLS*LEN_W-1:0]       i_col_len;
    logic                            i_valid;
    logic                            o_ready;
    logic                            i_last;
    logic [8*BUS_BYTES-1:0]          i_data;
    logic                            o_valid;
    logic                            i_ready;
    logic [NUM_COLS*8*MAX_COL_BYTES-1:0] o_col_data;
    logic                            o_err;
    modport master (
        output i_start, i_col_off, i_col_len, i_valid, i_last, i_data, i_ready,
        input  o_ready, o_valid, o_col_data, o_err
    );
    modport slave (
        input  i_start, i_col_off, i_col_len, i_valid, i_last, i_data, i_ready,
        output o_ready, o_valid, o_col_data, o_err
    );
endinterface

// File: rtl/col_ext_slot.sv
// col_ext_slot: one column accumulator merging in-range beat lanes, MSB-first, with clamp/short flag
module col_ext_slot import col_ext_pkg::*; #(
    parameter int BUS_BYTES     = 16,
    parameter int MAX_COL_BYTES = 64,
    parameter int OFF_W         = 8,
    parameter int LEN_W         = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         clr,
    input  logic                         vld,
    input  logic [OFF_W-1:0]             off,
    input  logic [LEN_W-1:0]             len,
    input  logic [OFF_W:0]               base,
    input  logic [OFF_W:0]               row_bytes,
    input  logic [8*BUS_BYTES-1:0]       data,
    output logic [8*MAX_COL_BYTES-1:0]   acc,
    output logic                         err
);
    localparam int KW = $clog2(MAX_COL_BYTES);
    localparam int CW = OFF_W + 1;
    localparam int SW = OFF_W + 2;
    logic [0:MAX_COL_BYTES-1][7:0] acc_q, acc_d;
    logic [0:BUS_BYTES-1][7:0]     lanes;
    logic [LEN_W-1:0]              len_c;
    logic [KW-1:0]                 k;
    logic                          clamp, short_row;
    assign lanes     = data;
    assign clamp     = len > LEN_W'(MAX_COL_BYTES);
    assign len_c     = clamp ? LEN_W'(MAX_COL_BYTES) : len;
    assign short_row = (len_c != '0) && (SW'(off) + SW'(len_c) > SW'(row_bytes));
    assign err       = clamp || short_row;
    assign acc       = acc_q;
    always_comb begin
        acc_d = acc_q;
        k     = '0;
        for (int l = 0; l < BUS_BYTES; l++) begin
            k = KW'(base + CW'(l) - CW'(off));
            if (vld && lane_hit(32'(base), 32'(off), 32'(len_c), 32'(l)))
                acc_d[k] = acc_d[k] | lanes[l];
        end
    end
    always_ff @(posedge i_clk)
        acc_q <= (i_rst || clr) ? '0 : acc_d;
endmodule

// File: rtl/col_extract_mc.sv
// col_extract_mc: extracts NUM_COLS byte-aligned columns from a beat-streamed row into packed slots
module col_extract_mc import col_ext_pkg::*; #(
    parameter int BUS_BYTES     = 16,
    parameter int MAX_COL_BYTES = 64,
    parameter int NUM_COLS      = 4,
    parameter int ROW_BYTES_MAX = 256
) (
    input logic              i_clk,
    input logic              i_rst,
    col_extract_mc_if.slave  bus
);
    localparam int OFF_W  = off_w(ROW_BYTES_MAX);
    localparam int LEN_W  = len_w(MAX_COL_BYTES);
    localparam int CW     = OFF_W + 1;
    localparam int SLOT_W = 8 * MAX_COL_BYTES;
    state_t                        state_q, state_d;
    logic [NUM_COLS*OFF_W-1:0]     off_q;
    logic [NUM_COLS*LEN_W-1:0]     len_q;
    logic [CW-1:0]                 cnt_q, s1_base;
    logic [8*BUS_BYTES-1:0]        s1_data;
    logic [NUM_COLS*SLOT_W-1:0]    col_data;
    logic [NUM_COLS-1:0]           col_err;
    logic                          s1_vld, ovf_q, hs, full, ld, clr;
    assign hs             = bus.i_valid && bus.o_ready;
    assign full           = cnt_q >= CW'(ROW_BYTES_MAX);
    assign ld             = (state_q == IDLE) && bus.i_start;
    assign clr            = ld || ((state_q == OUT) && bus.i_ready);
    assign bus.o_col_data = col_data;
    assign bus.o_err      = (state_q == OUT) && (ovf_q || |col_err);
    always_comb begin
        state_d     = state_q;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE:    state_d = bus.i_start ? COLLECT : IDLE;
            COLLECT: begin
                bus.o_ready = 1'b1;
                state_d     = (bus.i_valid && bus.i_last) ? FLUSH : COLLECT;
            end
            FLUSH:   state_d = OUT;
            OUT:     begin
                bus.o_valid = 1'b1;
                state_d     = bus.i_ready ? IDLE : OUT;
            end
            default: state_d = IDLE;
        endcase
    end
    // beats past the addressable row are dropped but remembered as an error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            s1_vld  <= 1'b0;
            s1_base <= '0;
            s1_data <= '0;
        end else begin
            state_q <= state_d;
            s1_vld  <= hs && !full;
            if (ld) begin
                off_q <= bus.i_col_off;
                len_q <= bus.i_col_len;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
            if (hs) begin
                s1_base <= cnt_q;
                s1_data <= bus.i_data;
                if (full) ovf_q <= 1'b1;
                else cnt_q <= cnt_q + CW'(BUS_BYTES);
            end
        end
    end
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        col_ext_slot #(
            .BUS_BYTES(BUS_BYTES), .MAX_COL_BYTES(MAX_COL_BYTES), .OFF_W(OFF_W), .LEN_W(LEN_W)
        ) u_slot (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .clr(clr),
            .vld(s1_vld),
            .off(off_q[c*OFF_W +: OFF_W]),
            .len(len_q[c*LEN_W +: LEN_W]),
            .base(s1_base),
            .row_bytes(cnt_q),
            .data(s1_data),
            .acc(col_data[c*SLOT_W +: SLOT_W]),
            .err(col_err[c])
        );
    end
endmodule
